// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage between the PC register and decode.
// Issues the current PC over a req/gnt/rvalid handshake, keeps the PC of every
// accepted request as a tag in an in-order ring, fills in the instruction when
// its response returns, and presents completed entries to decode.
// Three counters track the ring: occ (entries holding data), outst (granted
// requests still waiting for data) and drop (responses to discard after a flush).
module fetch_queue #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_en,
    input  logic [PC_WIDTH-1:0]   pc,
    output logic                  pc_stall,
    input  logic                  flush,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  id_valid,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic [PC_WIDTH-1:0]   id_pc,
    input  logic                  id_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW+1:0] DEPTH_L = (CW+2)'(DEPTH);

    // Ring pointers: tag write slot, oldest outstanding slot, decode head.
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rsp_ptr_reg, rsp_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;

    logic [CW-1:0] occ_reg, occ_next;
    logic [CW-1:0] outst_reg, outst_next;
    logic [CW-1:0] drop_reg, drop_next;

    logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];

    logic [DEPTH-1:0] pc_we;
    logic [DEPTH-1:0] inst_we;

    logic [CW+1:0] in_use;
    logic          has_room;
    logic          accept;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          rsp_in_flush;
    logic          pop;

    // Discarded responses still occupy a slot until they come back, so they
    // count against the bound together with queued and outstanding entries.
    assign in_use   = {2'b00, occ_reg} + {2'b00, outst_reg} + {2'b00, drop_reg};
    assign has_room = (in_use < DEPTH_L);

    // Request and stall are held low while reset is asserted so the memory
    // and the PC register see a quiet interface immediately.
    assign imem_req  = rst_n & cpu_en & ~flush & has_room;
    assign imem_addr = pc;
    assign accept    = imem_req & imem_gnt;
    assign pc_stall  = rst_n & cpu_en & ~flush & ~accept;

    // A response is kept only when nothing is pending discard and a request
    // is actually outstanding; a response during flush is always discarded.
    assign rsp_keep     = imem_rvalid & ~flush & (drop_reg == '0) & (outst_reg != '0);
    assign rsp_drop     = imem_rvalid & (drop_reg != '0);
    assign rsp_in_flush = imem_rvalid & ((drop_reg != '0) | (outst_reg != '0));

    assign id_valid = (occ_reg != '0);
    assign pop      = id_valid & id_ready & ~flush;

    assign id_inst = inst_mem[rd_ptr_reg];
    assign id_pc   = pc_mem[rd_ptr_reg];

    // Per-entry write enables decoded from the two write pointers.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign pc_we[gi]   = accept & (wr_ptr_reg == AW'(gi));
            assign inst_we[gi] = rsp_keep & (rsp_ptr_reg == AW'(gi));
        end
    endgenerate

    // Next-state for pointers and counters; flush collapses the ring and moves
    // every still-outstanding response into the discard count.
    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rsp_ptr_next = rsp_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        occ_next     = occ_reg;
        outst_next   = outst_reg;
        drop_next    = drop_reg;
        if (flush) begin
            wr_ptr_next  = '0;
            rsp_ptr_next = '0;
            rd_ptr_next  = '0;
            occ_next     = '0;
            outst_next   = '0;
            drop_next    = drop_reg + outst_reg - CW'(rsp_in_flush);
        end else begin
            wr_ptr_next  = wr_ptr_reg + AW'(accept);
            rsp_ptr_next = rsp_ptr_reg + AW'(rsp_keep);
            rd_ptr_next  = rd_ptr_reg + AW'(pop);
            occ_next     = occ_reg + CW'(rsp_keep) - CW'(pop);
            outst_next   = outst_reg + CW'(accept) - CW'(rsp_keep);
            drop_next    = drop_reg - CW'(rsp_drop);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rsp_ptr_reg <= '0;
            rd_ptr_reg  <= '0;
            occ_reg     <= '0;
            outst_reg   <= '0;
            drop_reg    <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rsp_ptr_reg <= rsp_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            occ_reg     <= occ_next;
            outst_reg   <= outst_next;
            drop_reg    <= drop_next;
        end
    end

    // Entry storage: PC tag written on acceptance, instruction on kept response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pc_we[i]) begin
                    pc_mem[i] <= pc;
                end
                if (inst_we[i]) begin
                    inst_mem[i] <= imem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue. The bench plays the PC
// register (advance by 4 on accept, load 0x100 on flush) and an in-order
// instruction memory answering with data {16'hC0DE, addr[15:0]}.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_en = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        pc_stall;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int grants = 0;
    logic [31:0] mq[$];

    localparam logic [31:0] REDIRECT = 32'h100;

    always #5 clk = ~clk;

    fetch_queue #(
        .PC_WIDTH  (32),
        .INST_WIDTH(32),
        .DEPTH     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_en     (cpu_en),
        .pc         (pc),
        .pc_stall   (pc_stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_ready   (id_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock: record acceptance for the memory model and update
    // the PC register model, both from values sampled before the edge.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        logic [31:0] pc_n;
        acc = rst_n && imem_req && imem_gnt;
        a   = imem_addr;
        if (!rst_n)                  pc_n = 32'h0;
        else if (flush)              pc_n = REDIRECT;
        else if (cpu_en && !pc_stall) pc_n = pc + 32'h4;
        else                         pc_n = pc;
        @(posedge clk);
        #1;
        if (acc) begin
            mq.push_back(a);
            grants++;
        end
        pc = pc_n;
    endtask

    // Memory response for this cycle from the oldest granted address.
    task automatic rsp(input bit en);
        logic [31:0] a;
        if (en && mq.size() > 0) begin
            a = mq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = {16'hC0DE, a[15:0]};
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic manual_rsp(input logic [31:0] data);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cpu_en = 1'b0;
        flush = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        id_ready = 1'b0;
        pc = 32'h0;
        mq.delete();
        grants = 0;
        #1;
        chk("rst_id_valid", id_valid, 32'h0);
        chk("rst_imem_req", imem_req, 32'h0);
        chk("rst_pc_stall", pc_stall, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // Three grants with the head left unread: occ=1, outst=2 afterwards.
    task automatic fill_1q_2o();
        cpu_en = 1'b1; imem_gnt = 1'b1; id_ready = 1'b0;
        rsp(1'b0); #1; tick();
        rsp(1'b1); #1; tick();
        rsp(1'b0); #1; tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- basic stream ----------------
        do_reset();
        #1;
        chk("idle_req", imem_req, 32'h0);
        chk("idle_stall", pc_stall, 32'h0);
        tick();
        cpu_en = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
        rsp(1'b1); #1;
        chk("s0_req", imem_req, 32'h1);
        chk("s0_addr", imem_addr, 32'h0);
        chk("s0_stall", pc_stall, 32'h0);
        chk("s0_valid", id_valid, 32'h0);
        tick();
        rsp(1'b1); #1;
        chk("s1_addr", imem_addr, 32'h4);
        chk("s1_stall", pc_stall, 32'h0);
        chk("s1_valid", id_valid, 32'h0);
        tick();
        rsp(1'b1); #1;
        chk("s2_valid", id_valid, 32'h1);
        chk("s2_pc", id_pc, 32'h0);
        chk("s2_inst", id_inst, 32'hC0DE0000);
        chk("s2_stall", pc_stall, 32'h0);
        tick();
        rsp(1'b1); #1;
        chk("s3_pc", id_pc, 32'h4);
        chk("s3_inst", id_inst, 32'hC0DE0004);
        chk("s3_stall", pc_stall, 32'h0);
        tick();
        rsp(1'b1); #1;
        chk("s4_pc", id_pc, 32'h8);
        chk("s4_inst", id_inst, 32'hC0DE0008);

        // ---------------- backpressure ----------------
        do_reset();
        cpu_en = 1'b1; imem_gnt = 1'b1; id_ready = 1'b0;
        rsp(1'b1); #1;
        chk("bp0_addr", imem_addr, 32'h0);
        tick();
        for (int i = 1; i < 4; i++) begin
            rsp(1'b1); #1;
            chk("bp_req", imem_req, 32'h1);
            chk("bp_addr", imem_addr, 32'(4 * i));
            tick();
        end
        rsp(1'b1); #1;
        chk("bp_full_req", imem_req, 32'h0);
        chk("bp_full_stall", pc_stall, 32'h1);
        tick();
        rsp(1'b1); id_ready = 1'b1; #1;
        chk("bp_pop_req", imem_req, 32'h0);
        chk("bp_pop_stall", pc_stall, 32'h1);
        chk("bp_pop_pc", id_pc, 32'h0);
        chk("bp_grants", grants, 32'd4);
        tick();
        rsp(1'b1); #1;
        chk("bp_next_req", imem_req, 32'h1);
        chk("bp_next_addr", imem_addr, 32'h10);
        chk("bp_next_stall", pc_stall, 32'h0);
        chk("bp_next_pc", id_pc, 32'h4);

        // ---------------- grant stall ----------------
        do_reset();
        cpu_en = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
        rsp(1'b1); #1; tick();
        rsp(1'b1); #1; tick();
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rsp(1'b1); #1;
            chk("gs_req", imem_req, 32'h1);
            chk("gs_addr", imem_addr, 32'h8);
            chk("gs_stall", pc_stall, 32'h1);
            if (i == 0) chk("gs_head_pc", id_pc, 32'h0);
            tick();
        end
        imem_gnt = 1'b1;
        rsp(1'b1); #1;
        chk("gs_go_addr", imem_addr, 32'h8);
        chk("gs_go_stall", pc_stall, 32'h0);

        // ---------------- flush, 2 outstanding + 1 queued ----------------
        do_reset();
        fill_1q_2o();
        flush = 1'b1; rsp(1'b0); #1;
        chk("fl_req", imem_req, 32'h0);
        chk("fl_stall", pc_stall, 32'h0);
        chk("fl_valid_cur", id_valid, 32'h1);
        tick();
        mq.delete();
        flush = 1'b0; manual_rsp(32'hDEAD0001); #1;
        chk("fl_valid_after", id_valid, 32'h0);
        chk("fl_redir_req", imem_req, 32'h1);
        chk("fl_redir_addr", imem_addr, 32'h100);
        tick();
        manual_rsp(32'hDEAD0002); #1;
        chk("fl_drop2_valid", id_valid, 32'h0);
        tick();
        imem_gnt = 1'b0; rsp(1'b1); #1;
        chk("fl_rsp_valid", id_valid, 32'h0);
        tick();
        rsp(1'b0); #1;
        chk("fl_new_valid", id_valid, 32'h1);
        chk("fl_new_pc", id_pc, 32'h100);
        chk("fl_new_inst", id_inst, 32'hC0DE0100);

        // ---------------- flush with rvalid and id_ready ----------------
        do_reset();
        fill_1q_2o();
        flush = 1'b1; id_ready = 1'b1; manual_rsp(32'hDEAD0003); #1;
        chk("fr_req", imem_req, 32'h0);
        chk("fr_valid_cur", id_valid, 32'h1);
        tick();
        mq.delete();
        flush = 1'b0; rsp(1'b0); #1;
        chk("fr_valid_after", id_valid, 32'h0);
        chk("fr_redir_addr", imem_addr, 32'h100);
        tick();
        manual_rsp(32'hDEAD0004); #1;
        chk("fr_drop_valid", id_valid, 32'h0);
        tick();
        imem_gnt = 1'b0; rsp(1'b1); #1;
        chk("fr_rsp_valid", id_valid, 32'h0);
        tick();
        rsp(1'b0); #1;
        chk("fr_new_valid", id_valid, 32'h1);
        chk("fr_new_pc", id_pc, 32'h100);
        chk("fr_new_inst", id_inst, 32'hC0DE0100);

        // ---------------- async reset mid-stream ----------------
        do_reset();
        cpu_en = 1'b1; imem_gnt = 1'b1; id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rsp(1'b1); #1; tick();
        end
        rsp(1'b0); #1;
        chk("ar_pre_valid", id_valid, 32'h1);
        chk("ar_pre_pc", id_pc, 32'h0);
        rst_n = 1'b0; #1;
        chk("ar_valid", id_valid, 32'h0);
        chk("ar_req", imem_req, 32'h0);
        chk("ar_stall", pc_stall, 32'h0);
        pc = 32'h0;
        mq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        id_ready = 1'b1;
        rsp(1'b0); #1;
        chk("ar_re_req", imem_req, 32'h1);
        chk("ar_re_addr", imem_addr, 32'h0);
        chk("ar_re_stall", pc_stall, 32'h0);
        chk("ar_re_valid", id_valid, 32'h0);
        tick();
        rsp(1'b1); #1;
        tick();
        rsp(1'b1); #1;
        chk("ar_out_valid", id_valid, 32'h1);
        chk("ar_out_pc", id_pc, 32'h0);
        chk("ar_out_inst", id_inst, 32'hC0DE0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
